// File: rtl/alu_share_arbiter_if.sv
// Requester-side and ALU-side signal bundle for the shared ALU arbiter.
interface alu_share_arbiter_if #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned VECTOR_SIZE = 4
) ();
  localparam int unsigned VW = 8 * VECTOR_SIZE;

  // Requester side
  logic [NUM_REQ-1:0]    req;
  logic [2*NUM_REQ-1:0]  req_arith;
  logic [NUM_REQ-1:0]    req_output_mux;
  logic [NUM_REQ-1:0]    req_vector_mux;
  logic [8*NUM_REQ-1:0]  req_rs;
  logic [8*NUM_REQ-1:0]  req_rt;
  logic [VW*NUM_REQ-1:0] req_v_rs;
  logic [VW*NUM_REQ-1:0] req_v_rt;
  logic [NUM_REQ-1:0]    done;
  logic [7:0]            rsp_out;
  logic [VW-1:0]         rsp_v_out;
  logic                  busy;

  // ALU side
  logic                  alu_enable;
  logic [2:0]            alu_core_state;
  logic [1:0]            alu_arith_mux;
  logic                  alu_output_mux;
  logic                  alu_vector_mux;
  logic [7:0]            alu_rs;
  logic [7:0]            alu_rt;
  logic [VW-1:0]         alu_v_rs;
  logic [VW-1:0]         alu_v_rt;
  logic [7:0]            alu_out;
  logic [VW-1:0]         alu_v_out;

  // Arbiter view
  modport slave (
    input  req, req_arith, req_output_mux, req_vector_mux,
    input  req_rs, req_rt, req_v_rs, req_v_rt,
    input  alu_out, alu_v_out,
    output done, rsp_out, rsp_v_out, busy,
    output alu_enable, alu_core_state, alu_arith_mux, alu_output_mux, alu_vector_mux,
    output alu_rs, alu_rt, alu_v_rs, alu_v_rt
  );

  // Requester/ALU environment view
  modport master (
    output req, req_arith, req_output_mux, req_vector_mux,
    output req_rs, req_rt, req_v_rs, req_v_rt,
    output alu_out, alu_v_out,
    input  done, rsp_out, rsp_v_out, busy,
    input  alu_enable, alu_core_state, alu_arith_mux, alu_output_mux, alu_vector_mux,
    input  alu_rs, alu_rt, alu_v_rs, alu_v_rt
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one scalar/vector ALU among NUM_REQ threads.
// Each op runs IDLE (grant) -> ISSUE (ALU execute) -> CAPTURE, done pulses after.
module alu_share_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned VECTOR_SIZE = 4
) (
  input logic                clk,
  input logic                reset,
  alu_share_arbiter_if.slave bus_io
);
  localparam int unsigned VW   = 8 * VECTOR_SIZE;
  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;

  state_e state_q, state_d;

  logic [PtrW-1:0]    rr_ptr_q, rr_ptr_d, grant_q, grant_d, win;
  logic               found;
  logic [NUM_REQ-1:0] elig, done_q, done_d;

  logic [1:0]    arith_q, arith_d;
  logic          omux_q, omux_d, vmux_q, vmux_d;
  logic [7:0]    rs_q, rs_d, rt_q, rt_d;
  logic [VW-1:0] v_rs_q, v_rs_d, v_rt_q, v_rt_d;
  logic [7:0]    rsp_q, rsp_d;
  logic [VW-1:0] rsp_v_q, rsp_v_d;

  // Round-robin search from rr_ptr; a requester finishing this cycle is masked
  // so its stale level request cannot win again.
  always_comb begin
    int unsigned k;
    logic [PtrW-1:0] idx;
    k     = 0;
    idx   = '0;
    elig  = bus_io.req & ~done_q;
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k   = (32'(rr_ptr_q) + i) % NUM_REQ;
      idx = PtrW'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (found) state_d = StIssue;
      StIssue:   state_d = StCapture;
      StCapture: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM outputs: the ALU only sees EXECUTE during ISSUE
  always_comb begin
    bus_io.alu_enable     = 1'b0;
    bus_io.alu_core_state = 3'b000;
    bus_io.busy           = (state_q != StIdle);
    if (state_q == StIssue) begin
      bus_io.alu_enable     = 1'b1;
      bus_io.alu_core_state = 3'b101;
    end
  end

  // Datapath next-state: latch winner's op on grant, capture result on CAPTURE
  always_comb begin
    int unsigned wi;
    wi       = 32'(win);
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    done_d   = '0;
    arith_d  = arith_q;
    omux_d   = omux_q;
    vmux_d   = vmux_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    v_rs_d   = v_rs_q;
    v_rt_d   = v_rt_q;
    rsp_d    = rsp_q;
    rsp_v_d  = rsp_v_q;
    if (state_q == StIdle && found) begin
      grant_d  = win;
      rr_ptr_d = PtrW'((wi + 32'd1) % NUM_REQ);
      arith_d  = bus_io.req_arith[2*wi +: 2];
      omux_d   = bus_io.req_output_mux[wi];
      vmux_d   = bus_io.req_vector_mux[wi];
      rs_d     = bus_io.req_rs[8*wi +: 8];
      rt_d     = bus_io.req_rt[8*wi +: 8];
      v_rs_d   = bus_io.req_v_rs[VW*wi +: VW];
      v_rt_d   = bus_io.req_v_rt[VW*wi +: VW];
    end
    if (state_q == StCapture) begin
      done_d[grant_q] = 1'b1;
      // Vector ops only update the vector result; scalar/compare only the scalar one
      if (vmux_q) rsp_v_d = bus_io.alu_v_out;
      else        rsp_d   = bus_io.alu_out;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      arith_q  <= '0;
      omux_q   <= 1'b0;
      vmux_q   <= 1'b0;
      rs_q     <= '0;
      rt_q     <= '0;
      v_rs_q   <= '0;
      v_rt_q   <= '0;
      rsp_q    <= '0;
      rsp_v_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      arith_q  <= arith_d;
      omux_q   <= omux_d;
      vmux_q   <= vmux_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      v_rs_q   <= v_rs_d;
      v_rt_q   <= v_rt_d;
      rsp_q    <= rsp_d;
      rsp_v_q  <= rsp_v_d;
    end
  end

  // Operands come straight from the issue registers, so the ALU inputs never glitch
  assign bus_io.alu_arith_mux  = arith_q;
  assign bus_io.alu_output_mux = omux_q;
  assign bus_io.alu_vector_mux = vmux_q;
  assign bus_io.alu_rs         = rs_q;
  assign bus_io.alu_rt         = rt_q;
  assign bus_io.alu_v_rs       = v_rs_q;
  assign bus_io.alu_v_rt       = v_rt_q;
  assign bus_io.done           = done_q;
  assign bus_io.rsp_out        = rsp_q;
  assign bus_io.rsp_v_out      = rsp_v_q;

endmodule
